// File: rtl/fp_issue_scoreboard_pkg.sv
// Shared widths and helpers for the FP issue scoreboard.
package fp_issue_scoreboard_pkg;

    localparam int unsigned FLEN_DEF         = 32;
    localparam int unsigned NUM_FREGS_DEF    = 32;
    localparam int unsigned MAX_INFLIGHT_DEF = 4;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_issue_scoreboard_tag_alloc.sv
// Priority encoder: lowest free slot index and an any-free flag.
module fp_issue_scoreboard_tag_alloc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     free_mask,
    output logic [IDX_W-1:0] free_idx_c,
    output logic             any_free_c
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        free_idx_c = '0;
        any_free_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx_c = IDX_W'(i);
                any_free_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_issue_scoreboard.sv
// In-order FP issue controller: RAW/WAW hazard stall, tag allocation,
// tag-to-register result mapping and a registered register-file write port.
module fp_issue_scoreboard
    import fp_issue_scoreboard_pkg::*;
#(
    parameter  int unsigned FLEN         = FLEN_DEF,
    parameter  int unsigned NUM_FREGS    = NUM_FREGS_DEF,
    parameter  int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    localparam int unsigned RA_W         = idx_width(NUM_FREGS),
    localparam int unsigned TAG_W        = idx_width(MAX_INFLIGHT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  logic [2:0]       dec_rs_used_i,
    input  logic [RA_W-1:0]  dec_rs1_i,
    input  logic [RA_W-1:0]  dec_rs2_i,
    input  logic [RA_W-1:0]  dec_rs3_i,
    input  logic [RA_W-1:0]  dec_rd_i,
    input  logic             dec_rd_we_i,
    output logic             fpu_valid_o,
    input  logic             fpu_ready_i,
    output logic [TAG_W-1:0] fpu_tag_o,
    input  logic             res_valid_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic [FLEN-1:0]  res_data_i,
    output logic             res_ready_o,
    output logic             rf_we_o,
    output logic [RA_W-1:0]  rf_waddr_o,
    output logic [FLEN-1:0]  rf_wdata_o,
    output logic [TAG_W:0]   inflight_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned NUM_SLOTS = 2 ** TAG_W;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [RA_W-1:0] rd;
    } slot_t;

    // Slot array is sized to the full tag space so any returned tag indexes
    // in range; slots at or above MAX_INFLIGHT are never allocated.
    slot_t                   slots [NUM_SLOTS];
    logic [NUM_FREGS-1:0]    busy;
    logic [TAG_W:0]          inflight_q;
    logic [MAX_INFLIGHT-1:0] free_mask;
    logic [TAG_W-1:0]        free_idx;
    logic                    any_free;
    logic                    hazard;
    logic                    can_issue;
    logic                    issue;
    slot_t                   res_slot;
    logic                    res_hit;

    // Free mask from registered slot state, so a slot freed this cycle is not reused until next cycle.
    always_comb begin
        free_mask = '0;
        for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
            free_mask[i] = ~slots[i].valid;
        end
    end

    fp_issue_scoreboard_tag_alloc #(
        .N     (MAX_INFLIGHT),
        .IDX_W (TAG_W)
    ) u_tag_alloc (
        .free_mask  (free_mask),
        .free_idx_c (free_idx),
        .any_free_c (any_free)
    );

    // RAW on any used source, WAW on the destination; registered busy bits only.
    always_comb begin
        hazard = 1'b0;
        if (dec_rs_used_i[0] && busy[dec_rs1_i]) hazard = 1'b1;
        if (dec_rs_used_i[1] && busy[dec_rs2_i]) hazard = 1'b1;
        if (dec_rs_used_i[2] && busy[dec_rs3_i]) hazard = 1'b1;
        if (dec_rd_we_i && busy[dec_rd_i])       hazard = 1'b1;
    end

    // Zero-cycle issue handshake with the FPU.
    always_comb begin
        can_issue   = ~hazard & any_free & ~rst_i;
        fpu_valid_o = dec_valid_i & can_issue;
        dec_ready_o = fpu_ready_i & can_issue;
        issue       = dec_valid_i & dec_ready_o;
        fpu_tag_o   = free_idx;
        res_slot    = slots[res_tag_i];
        res_hit     = res_valid_i & res_slot.valid;
        res_ready_o = 1'b1;
        inflight_o  = inflight_q;
        busy_o      = (inflight_q != '0);
    end

    // Slot, busy, counter, writeback and error state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slots[i] <= '0;
            end
            busy       <= '0;
            inflight_q <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rf_we_o <= res_hit & res_slot.we;
            if (res_hit) begin
                slots[res_tag_i].valid <= 1'b0;
                if (res_slot.we) begin
                    busy[res_slot.rd] <= 1'b0;
                    rf_waddr_o        <= res_slot.rd;
                    rf_wdata_o        <= res_data_i;
                end
            end
            if (res_valid_i && !res_slot.valid) begin
                err_o <= 1'b1;
            end
            // Issue never targets a register being cleared: that would be a WAW stall.
            if (issue) begin
                slots[free_idx] <= '{valid: 1'b1, we: dec_rd_we_i, rd: dec_rd_i};
                if (dec_rd_we_i) begin
                    busy[dec_rd_i] <= 1'b1;
                end
            end
            case ({issue, res_hit})
                2'b10:   inflight_q <= inflight_q + (TAG_W+1)'(1);
                2'b01:   inflight_q <= inflight_q - (TAG_W+1)'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Directed bench for fp_issue_scoreboard (FLEN=32, 32 regs, 4 in flight).
module tb_fp_issue_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [2:0]  dec_rs_used_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  dec_rs3_i;
    logic [4:0]  dec_rd_i;
    logic        dec_rd_we_i;
    logic        fpu_valid_o;
    logic        fpu_ready_i;
    logic [1:0]  fpu_tag_o;
    logic        res_valid_i;
    logic [1:0]  res_tag_i;
    logic [31:0] res_data_i;
    logic        res_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [2:0]  inflight_o;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_mis = 0;

    fp_issue_scoreboard dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dec_valid_i   (dec_valid_i),
        .dec_ready_o   (dec_ready_o),
        .dec_rs_used_i (dec_rs_used_i),
        .dec_rs1_i     (dec_rs1_i),
        .dec_rs2_i     (dec_rs2_i),
        .dec_rs3_i     (dec_rs3_i),
        .dec_rd_i      (dec_rd_i),
        .dec_rd_we_i   (dec_rd_we_i),
        .fpu_valid_o   (fpu_valid_o),
        .fpu_ready_i   (fpu_ready_i),
        .fpu_tag_o     (fpu_tag_o),
        .res_valid_i   (res_valid_i),
        .res_tag_i     (res_tag_i),
        .res_data_i    (res_data_i),
        .res_ready_o   (res_ready_o),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .inflight_o    (inflight_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; dec_valid_i = 1'b0; dec_rs_used_i = 3'b000;
        dec_rs1_i = '0; dec_rs2_i = '0; dec_rs3_i = '0;
        dec_rd_i = '0; dec_rd_we_i = 1'b0; fpu_ready_i = 1'b1;
        res_valid_i = 1'b0; res_tag_i = '0; res_data_i = '0;

        // Reset
        step(); step();
        chk("rst_dec_ready", dec_ready_o, 0);
        chk("rst_fpu_valid", fpu_valid_o, 0);
        chk("rst_fpu_tag", fpu_tag_o, 0);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_res_ready", res_ready_o, 1);
        rst_i = 1'b0;

        // RAW stall
        dec_valid_i = 1'b1; dec_rd_i = 5'd3; dec_rd_we_i = 1'b1;
        #1;
        chk("raw_issue0_ready", dec_ready_o, 1);
        chk("raw_issue0_valid", fpu_valid_o, 1);
        chk("raw_issue0_tag", fpu_tag_o, 0);
        step();
        dec_rs_used_i = 3'b001; dec_rs1_i = 5'd3; dec_rd_i = 5'd5;
        res_valid_i = 1'b1; res_tag_i = 2'd0; res_data_i = 32'hAAAA_0001;
        #1;
        chk("raw_stall_ready", dec_ready_o, 0);
        chk("raw_stall_valid", fpu_valid_o, 0);
        chk("raw_inflight1", inflight_o, 1);
        chk("raw_busy1", busy_o, 1);
        step();
        res_valid_i = 1'b0;
        #1;
        chk("raw_wb_we", rf_we_o, 1);
        chk("raw_wb_addr", rf_waddr_o, 3);
        chk("raw_wb_data", rf_wdata_o, 32'hAAAA_0001);
        chk("raw_inflight0", inflight_o, 0);
        chk("raw_dep_ready", dec_ready_o, 1);
        chk("raw_dep_tag", fpu_tag_o, 0);
        step();
        dec_valid_i = 1'b0;
        #1;
        chk("raw_wb_idle_we", rf_we_o, 0);
        chk("raw_wb_hold_addr", rf_waddr_o, 3);
        chk("raw_dep_inflight", inflight_o, 1);
        res_valid_i = 1'b1; res_tag_i = 2'd0; res_data_i = 32'h0000_5555;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("raw_dep_wb_we", rf_we_o, 1);
        chk("raw_dep_wb_addr", rf_waddr_o, 5);
        chk("raw_dep_wb_data", rf_wdata_o, 32'h0000_5555);
        chk("raw_drained_busy", busy_o, 0);

        // Full and out-of-order return
        dec_valid_i = 1'b1; dec_rs_used_i = 3'b000; dec_rd_we_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dec_rd_i = 5'(i + 1);
            #1;
            chk("full_alloc_tag", fpu_tag_o, 64'(i));
            step();
        end
        dec_rd_i = 5'd6;
        #1;
        chk("full_inflight4", inflight_o, 4);
        chk("full_stall_ready", dec_ready_o, 0);
        chk("full_stall_valid", fpu_valid_o, 0);
        res_valid_i = 1'b1; res_tag_i = 2'd2; res_data_i = 32'h0000_0033;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("ooo_wb_we", rf_we_o, 1);
        chk("ooo_wb_addr", rf_waddr_o, 3);
        chk("ooo_wb_data", rf_wdata_o, 32'h0000_0033);
        chk("ooo_inflight3", inflight_o, 3);
        chk("ooo_reuse_ready", dec_ready_o, 1);
        chk("ooo_reuse_tag", fpu_tag_o, 2);
        step();

        // Same-cycle result and issue while full
        dec_rd_i = 5'd7;
        res_valid_i = 1'b1; res_tag_i = 2'd0; res_data_i = 32'h0000_00D0;
        #1;
        chk("sim_inflight4", inflight_o, 4);
        chk("sim_stall_ready", dec_ready_o, 0);
        step();
        res_valid_i = 1'b0;
        #1;
        chk("sim_next_ready", dec_ready_o, 1);
        chk("sim_next_tag", fpu_tag_o, 0);
        chk("sim_wb_addr", rf_waddr_o, 1);
        chk("sim_wb_data", rf_wdata_o, 32'h0000_00D0);
        chk("sim_inflight3", inflight_o, 3);
        step();
        dec_valid_i = 1'b0;
        #1;
        chk("sim_refill_inflight", inflight_o, 4);
        for (int t = 0; t < 4; t++) begin
            res_valid_i = 1'b1; res_tag_i = 2'(t); res_data_i = 32'(32'hE0 + t);
            step();
        end
        res_valid_i = 1'b0;
        #1;
        chk("drain_wb_we", rf_we_o, 1);
        chk("drain_wb_addr", rf_waddr_o, 4);
        chk("drain_wb_data", rf_wdata_o, 32'h0000_00E3);
        chk("drain_inflight", inflight_o, 0);
        chk("drain_busy", busy_o, 0);

        // Non-writing op
        dec_valid_i = 1'b1; dec_rs_used_i = 3'b000; dec_rd_i = 5'd9; dec_rd_we_i = 1'b0;
        #1;
        chk("nw_issue_tag", fpu_tag_o, 0);
        step();
        dec_valid_i = 1'b0; dec_rs_used_i = 3'b001; dec_rs1_i = 5'd9; dec_rd_i = 5'd9; dec_rd_we_i = 1'b1;
        #1;
        chk("nw_inflight1", inflight_o, 1);
        chk("nw_no_hazard_ready", dec_ready_o, 1);
        chk("nw_next_tag", fpu_tag_o, 1);
        res_valid_i = 1'b1; res_tag_i = 2'd0; res_data_i = 32'h0000_0099;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("nw_wb_we", rf_we_o, 0);
        chk("nw_wb_hold_addr", rf_waddr_o, 4);
        chk("nw_wb_hold_data", rf_wdata_o, 32'h0000_00E3);
        chk("nw_inflight0", inflight_o, 0);
        chk("nw_err_clear", err_o, 0);

        // Unknown tag
        res_valid_i = 1'b1; res_tag_i = 2'd1; res_data_i = 32'h0000_0077;
        step();
        res_valid_i = 1'b0;
        #1;
        chk("unk_err_set", err_o, 1);
        chk("unk_inflight", inflight_o, 0);
        chk("unk_busy", busy_o, 0);
        chk("unk_wb_we", rf_we_o, 0);
        chk("unk_wb_addr", rf_waddr_o, 4);
        step();
        chk("unk_err_sticky", err_o, 1);
        rst_i = 1'b1;
        step();
        chk("unk_err_reset", err_o, 0);
        chk("unk_rst_ready", dec_ready_o, 0);
        rst_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
